// File: rtl/addsub_serial_pkg.sv
// Shared encodings for the digit-serial adder-subtractor: FSM states and op codes.
package addsub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; c_msb is the carry into the top bit,
// which the top level needs for signed overflow on the last digit.
module addsub_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co,
  output logic             c_msb
);

  logic [DIGIT:0] carry;

  always_comb begin
    carry    = '0;
    carry[0] = ci;
    for (int i = 0; i < DIGIT; i++) begin
      carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
    end
    sum   = x ^ y ^ carry[DIGIT-1:0];
    co    = carry[DIGIT];
    c_msb = carry[DIGIT-1];
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial WIDTH-bit adder-subtractor: DIGIT bits per clock, one operation
// in flight, valid/ready on both sides.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; a producer holding valid must keep its data stable until that edge.
module addsub_serial
  import addsub_serial_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              carry_q;
  logic [CW-1:0]     cnt_q;
  logic [WIDTH-1:0]  s_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;
  logic              out_valid_q;

  logic [DIGIT-1:0]  dx;
  logic [DIGIT-1:0]  dy;
  logic [DIGIT-1:0]  dsum;
  logic              dco;
  logic              dc_msb;
  logic [WIDTH-1:0]  s_next;
  logic              accept;

  assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Current digit of each operand, and the result with that digit merged in.
  always_comb begin
    dx     = a_q[int'(cnt_q) * DIGIT +: DIGIT];
    dy     = b_q[int'(cnt_q) * DIGIT +: DIGIT];
    s_next = s_q;
    s_next[int'(cnt_q) * DIGIT +: DIGIT] = dsum;
  end

  addsub_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (dx),
    .y     (dy),
    .ci    (carry_q),
    .sum   (dsum),
    .co    (dco),
    .c_msb (dc_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            // Subtraction is A + ~B + 1: invert B here, the +1 rides in as carry-in.
            a_q     <= a;
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= (sub == OP_SUB);
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q     <= s_next;
          carry_q <= dco;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= dco;
            ovf_q       <= dco ^ dc_msb;
            zero_q      <= (s_next == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            if (in_valid) begin
              a_q     <= a;
              b_q     <= b ^ {WIDTH{sub}};
              carry_q <= (sub == OP_SUB);
              cnt_q   <= '0;
              state_q <= RUN;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, digit-serial adder-subtractor; generalises the team's fixed 4-bit ripple adder-subtractor to WIDTH bits.
- Computes DIGIT bits per clock, trading latency for area.
- Valid/ready handshakes on input and output; reports carry/borrow, signed overflow and zero flags.
- Sits between operand registers and a result consumer in the datapath; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands present
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = A+B, 1 = A-B; sampled with operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- s  out  WIDTH  sum/difference, modulo 2^WIDTH
- cout  out  1  raw carry out of MSB; for sub, 1 = no borrow
- ovf  out  1  two's-complement signed overflow
- zero  out  1  s == 0

Behaviour:
- Reset: state IDLE, out_valid=0, s=0, cout=0, ovf=0, zero=0, digit counter=0. in_ready=1 in the first cycle after reset.
- rst has priority over every other event. Asserting it mid-RUN or in DONE aborts the operation, discards the result and produces no out_valid.
- Let N = WIDTH/DIGIT.
- FSM states: IDLE, RUN, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- Accept occurs on an edge where in_valid && in_ready. On accept:
  - latch a, sub;
  - latch b XOR {WIDTH{sub}};
  - load carry register with sub;
  - clear counter;
  - go to RUN.
- RUN: each cycle adds digit k (bits k*DIGIT .. k*DIGIT+DIGIT-1) of A and B', with the carry register as carry-in.
  - Write the digit sum into the result register.
  - Store the digit carry-out in the carry register; increment k.
- On the edge completing digit N-1:
  - go to DONE, set out_valid=1;
  - cout = final carry;
  - ovf = carry into MSB XOR carry out of MSB;
  - zero = (full result == 0).
- Latency: out_valid rises exactly N cycles after the accept edge (N=4 at defaults).
- DONE: s/cout/ovf/zero are held stable while out_valid && !out_ready, for any number of cycles.
- The output handshake completes on an edge with out_valid && out_ready:
  - if in_valid is high the same edge, accept the new operands and go to RUN (out_valid=0 next cycle);
  - otherwise go to IDLE, out_valid=0.
- Back-to-back throughput: one result per N+1 cycles.
- in_valid without in_ready: operands are ignored; the producer must hold them.
- Inputs a/b/sub may change freely after accept without affecting the result.
- DIGIT == WIDTH: N=1; degenerates to a one-cycle registered adder-subtractor; all rules still apply.
- Outputs s/cout/ovf/zero retain their last value after leaving DONE. They are only meaningful while out_valid=1.

Decomposition:
- Shared package constants:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - op encoding (OP_ADD=1'b0, OP_SUB=1'b1).
- Sub-module addsub_digit:
  - pure combinational DIGIT-bit ripple slice;
  - inputs x[DIGIT], y[DIGIT], ci;
  - outputs sum[DIGIT], co, and c_msb (carry into the top bit, used for ovf on the last digit).
- Top level holds the FSM, counter, operand shift/select, carry register and flag logic.

Test Plan:
- Add with signed overflow (WIDTH=16, DIGIT=4): a=16'h7FFF, b=16'h0001, sub=0 -> after 4 cycles: s=16'h8000, cout=0, ovf=1, zero=0.
- Equal subtract: a=16'h0005, b=16'h0005, sub=1 -> s=16'h0000, cout=1, ovf=0, zero=1.
- Borrow: a=16'h0000, b=16'h0001, sub=1 -> s=16'hFFFF, cout=0, ovf=0.
- Unsigned carry: a=16'hFFFF, b=16'h0001, sub=0 -> s=16'h0000, cout=1, ovf=0, zero=1.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> outputs stable and in_ready=0 throughout. Then raise out_ready with in_valid=1 (a=16'h8000, b=16'h0001, sub=1) -> accepted the same edge; next result s=16'h7FFF, ovf=1 after 4 more cycles.
- Reset mid-RUN: assert rst 2 cycles after accept -> next cycle out_valid=0, in_ready=1, s=0. No result from the aborted op; a following op a=3, b=4, sub=0 yields s=7.
- Repeat the sum/overflow cases with DIGIT=1 and DIGIT=16: latency 16 and 1 cycles respectively, identical results.
